blocpu_uart_loader: RTL and testbench

//  Upstream boot stage for blocpu_core. Consumes the byte stream from async_receiver,

---
 rtl/blocpu_uart_loader_pkg.sv | 35 +++
 rtl/blocpu_uart_loader_if.sv | 37 +++
 rtl/blocpu_uart_loader_reply_tx.sv | 60 ++++++
 rtl/blocpu_uart_loader.sv | 188 ++++++++++++++++++
 tb/tb_blocpu_uart_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/blocpu_uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blocpu_uart_loader_pkg
// Brief    : Shared reply codes, default frame header and loader state encoding
//            for the UART boot loader and anything that decodes its state.
// Revision : 1.0 - initial release
// ============================================================================
package blocpu_uart_loader_pkg;

    localparam logic [7:0] ACK_CODE          = 8'h06;
    localparam logic [7:0] NAK_CODE          = 8'h15;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB1;

    // Loader states, kept as plain constants so external decoders can share them
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_LO    = 3'd2;
    localparam logic [2:0] ST_HI    = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_BOOT  = 3'd5;
    localparam logic [2:0] ST_RUN   = 3'd6;

    // One reply request from the framer towards the transmitter side
    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } reply_t;

    // True in the states where the inter-byte timeout is armed
    function automatic logic in_frame(input logic [2:0] st);
        return (st == ST_COUNT) || (st == ST_LO) || (st == ST_HI) || (st == ST_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blocpu_uart_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : blocpu_uart_loader_if
// Brief    : Bundle of UART, instruction-memory and core-control signals seen
//            by the boot loader. master = loader side, slave = environment.
// Revision : 1.0 - initial release
// ============================================================================
interface blocpu_uart_loader_if #(
    parameter int INSTR_WIDTH = 12,
    parameter int ADDR_WIDTH  = 8
);
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   tx_busy;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   imem_we;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_wdata;
    logic                   core_reset;
    logic                   core_run;
    logic                   core_running;
    logic                   error;

    modport master (
        input  rx_valid, rx_data, tx_busy, core_running,
        output tx_start, tx_data, imem_we, imem_addr, imem_wdata,
               core_reset, core_run, error
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, core_running,
        input  tx_start, tx_data, imem_we, imem_addr, imem_wdata,
               core_reset, core_run, error
    );
endinterface
`default_nettype wire

// File: rtl/blocpu_uart_loader_reply_tx.sv
`default_nettype none
// ============================================================================
// Module   : blocpu_uart_loader_reply_tx
// Brief    : One-entry reply holding register. Launches the pending byte on the
//            first idle transmitter cycle; a newer request replaces an older one.
// Revision : 1.0 - initial release
// ============================================================================
module blocpu_uart_loader_reply_tx
    import blocpu_uart_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  reply_t     req_i,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o
);

    logic       pend_q,  pend_d;
    logic [7:0] code_q,  code_d;
    logic       start_q, start_d;
    logic [7:0] data_q,  data_d;

    // A launch is skipped while the previous strobe is still high, because the
    // transmitter only raises busy on the cycle after it sees tx_start.
    always_comb begin
        pend_d  = pend_q;
        code_d  = code_q;
        start_d = 1'b0;
        data_d  = data_q;
        if (req_i.valid) begin
            pend_d = 1'b1;
            code_d = req_i.code;
        end else if (pend_q && !tx_busy_i && !start_q) begin
            start_d = 1'b1;
            data_d  = code_q;
            pend_d  = 1'b0;
        end
    end

    // Reply registers; tx_data only changes when a new strobe is launched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= 1'b0;
            code_q  <= 8'h00;
            start_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            pend_q  <= pend_d;
            code_q  <= code_d;
            start_q <= start_d;
            data_q  <= data_d;
        end
    end

    assign tx_start_o = start_q;
    assign tx_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/blocpu_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : blocpu_uart_loader
// Brief    : Frames the UART byte stream SYNC,N,{LO,HI}xN,CSUM into instruction
//            words, writes them to instruction memory, boots the core on a good
//            frame and answers ACK/NAK.
// Revision : 1.0 - initial release
// ============================================================================
module blocpu_uart_loader
    import blocpu_uart_loader_pkg::*;
#(
    parameter int         INSTR_WIDTH    = 12,
    parameter int         ADDR_WIDTH     = 8,
    parameter int         IMEM_DEPTH     = 256,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    blocpu_uart_loader_if.master bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [7:0]             lo_q, lo_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   core_reset_q, core_reset_d;
    logic                   core_run_q, core_run_d;
    logic                   error_q, error_d;
    logic                   running_q;
    reply_t                 reply_req;

    // Frame parser, boot sequencer and inter-byte timeout
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        lo_d         = lo_q;
        tmo_d        = '0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_reset_d = 1'b0;
        core_run_d   = core_run_q;
        error_d      = error_q;
        reply_req    = '{valid: 1'b0, code: ACK_CODE};

        if (in_frame(state_q) && !bus.rx_valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'h00 || 32'(bus.rx_data) > IMEM_DEPTH) begin
                        reply_req = '{valid: 1'b1, code: NAK_CODE};
                        error_d   = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d   = bus.rx_data;
                        idx_d   = '0;
                        csum_d  = bus.rx_data;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (bus.rx_valid) begin
                    lo_d    = bus.rx_data;
                    csum_d  = csum_q ^ bus.rx_data;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (bus.rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = {bus.rx_data[INSTR_WIDTH-9:0], lo_q};
                    csum_d  = csum_q ^ bus.rx_data;
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = (32'(idx_q) == 32'(cnt_q) - 32'd1) ? ST_CSUM : ST_LO;
                end
            end
            ST_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        reply_req    = '{valid: 1'b1, code: ACK_CODE};
                        error_d      = 1'b0;
                        core_reset_d = 1'b1;
                        state_d      = ST_BOOT;
                    end else begin
                        reply_req = '{valid: 1'b1, code: NAK_CODE};
                        error_d   = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_BOOT: begin
                core_run_d = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    core_run_d = 1'b0;
                    state_d    = ST_COUNT;
                end else if (running_q && !bus.core_running) begin
                    core_run_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte arriving on the expiry cycle takes priority over the timeout
        if (in_frame(state_q) && !bus.rx_valid && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            reply_req = '{valid: 1'b1, code: NAK_CODE};
            error_d   = 1'b1;
            tmo_d     = '0;
            state_d   = ST_IDLE;
        end
    end

    // Loader state registers; core_reset is held high throughout reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'h00;
            idx_q        <= '0;
            csum_q       <= 8'h00;
            lo_q         <= 8'h00;
            tmo_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
            error_q      <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            lo_q         <= lo_d;
            tmo_q        <= tmo_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            core_run_q   <= core_run_d;
            error_q      <= error_d;
            running_q    <= bus.core_running;
        end
    end

    blocpu_uart_loader_reply_tx u_reply_tx (
        .clk        (clk),
        .reset      (reset),
        .req_i      (reply_req),
        .tx_busy_i  (bus.tx_busy),
        .tx_start_o (bus.tx_start),
        .tx_data_o  (bus.tx_data)
    );

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.core_run   = core_run_q;
    assign bus.error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_blocpu_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_blocpu_uart_loader
// Brief    : Scoreboard bench for the UART boot loader. Frames are built at
//            byte level; expected memory writes and replies are derived from
//            the frame contents and matched by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blocpu_uart_loader;

    localparam int         IW    = 12;
    localparam int         AW    = 8;
    localparam int         DEPTH = 16;
    localparam int         TMO   = 50;
    localparam logic [7:0] SYNC  = 8'hB1;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    blocpu_uart_loader_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

    blocpu_uart_loader #(
        .INSTR_WIDTH    (IW),
        .ADDR_WIDTH     (AW),
        .IMEM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  pl[$];

    // Simple transmitter: busy for a few cycles after each start, or forced busy
    int   busy_cnt  = 0;
    logic hold_busy = 1'b0;
    assign bus.tx_busy = hold_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        if (bus.tx_start) busy_cnt <= 6;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h expected no event", nm, act);
    endtask

    // Monitor: every memory write and reply strobe must match the scoreboard head
    always @(negedge clk) begin
        if (bus.imem_we) begin
            if (exp_wr.size() == 0) unexpected("imem_write_extra", {12'd0, bus.imem_addr, bus.imem_wdata});
            else chk("imem_write", {12'd0, bus.imem_addr, bus.imem_wdata}, exp_wr.pop_front());
        end
        if (bus.tx_start) begin
            if (exp_tx.size() == 0) unexpected("tx_reply_extra", 32'(bus.tx_data));
            else chk("tx_reply", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_wr.size() != 0 || exp_tx.size() != 0) && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk({nm, "_drain"}, 32'(exp_wr.size() + exp_tx.size()), 32'd0);
        idle(3);
    endtask

    // Sends SYNC, n, payload pl, checksum; expectations come from the frame rules
    task automatic send_frame(input logic [7:0] n, input bit corrupt, input bit from_run);
        logic [7:0] cs;
        int nw;
        cs = n;
        foreach (pl[i]) cs = cs ^ pl[i];
        if (corrupt) cs = cs ^ 8'h5A;
        nw = pl.size() / 2;
        for (int i = 0; i < nw; i++)
            exp_wr.push_back(32'((i << IW) | ((int'(pl[2*i+1]) & 'h0F) << 8) | int'(pl[2*i])));
        exp_tx.push_back(corrupt ? NAK : ACK);
        send_byte(SYNC);
        if (from_run) chk("run_drop_on_sync", 32'(bus.core_run), 32'd0);
        idle($urandom_range(0, 3));
        send_byte(n);
        foreach (pl[i]) begin
            idle($urandom_range(0, 3));
            send_byte(pl[i]);
        end
        idle($urandom_range(0, 3));
        send_byte(cs);
        if (!corrupt) begin
            chk("boot_core_reset", 32'({bus.core_reset, bus.core_run}), 32'b10);
            @(posedge clk); #1;
            chk("boot_core_run", 32'({bus.core_reset, bus.core_run}), 32'b01);
        end
        if (hold_busy) begin
            idle(20);
            chk("tx_held_while_busy", 32'(exp_tx.size()), 32'd1);
            hold_busy = 1'b0;
        end
        drain("frame");
        chk("error_after_frame", 32'(bus.error), 32'(corrupt));
        chk("core_run_after_frame", 32'(bus.core_run), 32'(!corrupt));
    endtask

    task automatic stop_core();
        bus.core_running = 1'b1;
        idle(2);
        bus.core_running = 1'b0;
        idle(2);
        chk("core_stop", 32'(bus.core_run), 32'd0);
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < 2 * n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic bad_count(input logic [7:0] n);
        exp_tx.push_back(NAK);
        send_byte(SYNC);
        send_byte(n);
        drain("bad_count");
        chk("bad_count_error", 32'(bus.error), 32'd1);
    endtask

    initial begin
        int  n;
        bit  c;
        logic [7:0] junk;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = 8'h00;
        bus.core_running = 1'b0;
        reset            = 1'b1;
        idle(3);
        chk("reset_outputs", 32'({bus.tx_start, bus.imem_we, bus.core_run, bus.error, bus.core_reset}), 32'b00001);
        reset = 1'b0;
        idle(2);
        chk("core_reset_released", 32'(bus.core_reset), 32'd0);

        // Basic two-word frame, then reload while running
        pl = '{8'h2A, 8'h02, 8'h01, 8'h01};
        send_frame(8'd2, 1'b0, 1'b0);
        bus.core_running = 1'b1;
        pl = '{8'h00, 8'h00};
        send_frame(8'd1, 1'b0, 1'b1);
        stop_core();

        // Bad checksum: writes still happen, NAK, error set
        pl = '{8'h2A, 8'h02, 8'h01, 8'h01};
        send_frame(8'd2, 1'b1, 1'b0);

        // Junk in IDLE is ignored; next good frame clears error
        for (int k = 0; k < 3; k++) begin
            junk = 8'($urandom);
            if (junk == SYNC) junk = 8'h00;
            send_byte(junk);
        end
        pl = '{8'hFF, 8'h0F};
        send_frame(8'd1, 1'b0, 1'b0);
        stop_core();

        // Largest accepted frame
        rand_payload(DEPTH);
        send_frame(8'(DEPTH), 1'b0, 1'b0);
        stop_core();

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, DEPTH);
            c = ($urandom_range(0, 3) == 0);
            rand_payload(n);
            send_frame(8'(n), c, 1'b0);
            if (!c) stop_core();
        end

        // Rejected counts
        bad_count(8'd0);
        bad_count(8'(DEPTH + 1));

        // Inter-byte timeout, then a fresh frame
        exp_tx.push_back(NAK);
        send_byte(SYNC);
        send_byte(8'd3);
        send_byte(8'h2A);
        idle(TMO + 10);
        drain("timeout");
        chk("timeout_error", 32'(bus.error), 32'd1);
        chk("timeout_core_run", 32'(bus.core_run), 32'd0);
        rand_payload(2);
        send_frame(8'd2, 1'b0, 1'b0);
        stop_core();

        // Reply held back while transmitter busy
        hold_busy = 1'b1;
        rand_payload(1);
        send_frame(8'd1, 1'b0, 1'b0);
        stop_core();

        // Reset in the middle of a frame
        send_byte(SYNC);
        send_byte(8'd2);
        idle(1);
        reset = 1'b1;
        #1;
        chk("reset_mid_frame", 32'({bus.tx_start, bus.imem_we, bus.core_run, bus.error, bus.core_reset}), 32'b00001);
        idle(3);
        reset = 1'b0;
        idle(2);
        send_byte(8'h55);
        idle(4);
        rand_payload(3);
        send_frame(8'd3, 1'b0, 1'b0);
        stop_core();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
